// File: rtl/regfile_writeback.sv
// Register-file writeback queue: merges ALU and load results into one
// ordered stream of one-hot register-bank writes.
module regfile_writeback #(
  parameter int DEPTH         = 4,
  parameter int RESERVED_BASE = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [3:0]              alu_dest,
  input  logic [15:0]             alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [3:0]              mem_dest,
  input  logic [15:0]             mem_data,
  input  logic                    priv,
  input  logic                    wb_stall,
  output logic [15:0]             rEnable,
  output logic [15:0]             writePort,
  output logic [15:0]             pending,
  output logic                    drop_err,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] RB = 4'(RESERVED_BASE);

  logic [3:0]    dest_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] alu_slot;
  logic [PW-1:0] off;

  logic mem_fire, alu_fire;
  logic mem_keep, alu_keep;
  logic pop;

  assign mem_ready = reset && (count < CW'(DEPTH));
  assign alu_ready = reset &&
    ((count <= CW'(DEPTH - 2)) ||
     ((count == CW'(DEPTH - 1)) && !mem_valid));

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  // Protected registers are writable only with priv set
  assign mem_keep = mem_fire && !((mem_dest >= RB) && !priv);
  assign alu_keep = alu_fire && !((alu_dest >= RB) && !priv);

  assign pop      = (count != '0) && !wb_stall;
  assign alu_slot = wr_ptr + PW'(mem_keep);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rEnable   <= '0;
      writePort <= '0;
      drop_err  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(mem_keep) + PW'(alu_keep);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + CW'(mem_keep) + CW'(alu_keep) - CW'(pop);
      drop_err <= (mem_fire && !mem_keep) || (alu_fire && !alu_keep);
      if (pop) begin
        rEnable   <= 16'h0001 << dest_q[rd_ptr];
        writePort <= data_q[rd_ptr];
      end else begin
        rEnable   <= '0;
      end
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (mem_keep) begin
      dest_q[wr_ptr] <= mem_dest;
      data_q[wr_ptr] <= mem_data;
    end
    if (alu_keep) begin
      dest_q[alu_slot] <= alu_dest;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_comb begin
    pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count) pending[dest_q[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table plus
// full/stall and mid-queue reset sequences.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_dest;
  logic [15:0] mem_data;
  logic        priv, wb_stall;
  logic [15:0] rEnable, writePort, pending;
  logic        drop_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.DEPTH(DEPTH), .RESERVED_BASE(13)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dest(mem_dest), .mem_data(mem_data),
    .priv(priv), .wb_stall(wb_stall),
    .rEnable(rEnable), .writePort(writePort),
    .pending(pending), .drop_err(drop_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic [15:0] adat;
    logic        mv;
    logic [3:0]  md;
    logic [15:0] mdat;
    logic        pr;
    logic [15:0] e_ren;
    logic [15:0] e_wp;
    logic [15:0] e_pend;
    logic        e_drop;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_dest  = '0;
    alu_data  = '0;
    mem_dest  = '0;
    mem_data  = '0;
    priv      = 1'b0;
  endtask

  task automatic push_alu(input logic [3:0] d, input logic [15:0] v);
    @(negedge clk);
    alu_valid = 1'b1;
    alu_dest  = d;
    alu_data  = v;
    priv      = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ren,
                         input logic [15:0] wp, input logic [15:0] pend,
                         input logic drop, input logic [2:0] cnt);
    chk({tag, ".rEnable"}, 32'(rEnable), 32'(ren));
    chk({tag, ".writePort"}, 32'(writePort), 32'(wp));
    chk({tag, ".pending"}, 32'(pending), 32'(pend));
    chk({tag, ".drop_err"}, 32'(drop_err), 32'(drop));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    // av ad adat mv md mdat pr | ren wp pend drop cnt
    vt[0]  = '{1, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1};
    vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'hBEEF, 16'h0000, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 0};
    vt[3]  = '{1, 5, 16'h2222, 1, 5, 16'h1111, 0,
               16'h0000, 16'hBEEF, 16'h0020, 0, 2};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0020, 16'h1111, 16'h0020, 0, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0020, 16'h2222, 16'h0000, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h2222, 16'h0000, 0, 0};
    vt[7]  = '{1, 14, 16'hAAAA, 0, 0, 0, 0,
               16'h0000, 16'h2222, 16'h0000, 1, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h2222, 16'h0000, 0, 0};
    vt[9]  = '{1, 14, 16'hAAAA, 0, 0, 0, 1,
               16'h0000, 16'h2222, 16'h4000, 0, 1};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 16'h4000, 16'hAAAA, 16'h0000, 0, 0};
    vt[11] = '{1, 13, 16'h0001, 1, 15, 16'h0002, 0,
               16'h0000, 16'hAAAA, 16'h0000, 1, 0};
    vt[12] = '{1, 2, 16'h0202, 1, 13, 16'h0D0D, 0,
               16'h0000, 16'hAAAA, 16'h0004, 1, 1};
    vt[13] = '{1, 7, 16'h0707, 0, 0, 0, 0, 16'h0004, 16'h0202, 16'h0080, 0, 1};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 16'h0080, 16'h0707, 16'h0000, 0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0707, 16'h0000, 0, 0};

    idle_inputs();
    wb_stall = 1'b0;
    reset    = 1'b0;
    #2;
    chk_all("reset", 16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
    chk("reset.alu_ready", 32'(alu_ready), 32'd0);
    chk("reset.mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel.alu_ready", 32'(alu_ready), 32'd1);
    chk("rel.mem_ready", 32'(mem_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alu_valid = vt[i].av;
      alu_dest  = vt[i].ad;
      alu_data  = vt[i].adat;
      mem_valid = vt[i].mv;
      mem_dest  = vt[i].md;
      mem_data  = vt[i].mdat;
      priv      = vt[i].pr;
      @(posedge clk);
      #1;
      idle_inputs();
      chk_all($sformatf("vec%0d", i), vt[i].e_ren, vt[i].e_wp,
              vt[i].e_pend, vt[i].e_drop, vt[i].e_cnt);
      chk($sformatf("vec%0d.mem_ready", i), 32'(mem_ready),
          32'(vt[i].e_cnt < 3'(DEPTH)));
    end

    // Fill under stall; at DEPTH-1 only the load side may enter
    @(negedge clk);
    wb_stall = 1'b1;
    push_alu(4'd1, 16'h1001);
    push_alu(4'd2, 16'h1002);
    push_alu(4'd3, 16'h1003);
    chk("fill.count3", 32'(count), 32'd3);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_dest  = 4'd4;
    mem_data  = 16'h1004;
    alu_valid = 1'b1;
    alu_dest  = 4'd5;
    alu_data  = 16'h1005;
    #1;
    chk("fill.alu_ready_blocked", 32'(alu_ready), 32'd0);
    chk("fill.mem_ready_open", 32'(mem_ready), 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    chk_all("full", 16'h0, 16'h0707, 16'h001E, 1'b0, 3'd4);
    chk("full.alu_ready", 32'(alu_ready), 32'd0);
    chk("full.mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("drain%0d.rEnable", k), 32'(rEnable),
          32'(16'h0002 << k));
      chk($sformatf("drain%0d.writePort", k), 32'(writePort),
          32'(16'h1001 + 16'(k)));
      chk($sformatf("drain%0d.count", k), 32'(count), 32'(3 - k));
    end
    @(posedge clk);
    #1;
    chk_all("drained", 16'h0, 16'h1004, 16'h0, 1'b0, 3'd0);

    // Reset with three entries queued
    @(negedge clk);
    wb_stall = 1'b1;
    push_alu(4'd8, 16'h0808);
    push_alu(4'd9, 16'h0909);
    push_alu(4'd10, 16'h0A0A);
    chk("rq.pending", 32'(pending), 32'h0700);
    #2;
    reset = 1'b0;
    #1;
    chk_all("rq.async", 16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
    chk("rq.alu_ready", 32'(alu_ready), 32'd0);
    chk("rq.mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    wb_stall = 1'b0;
    reset    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post%0d", k), 16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
      chk($sformatf("post%0d.alu_ready", k), 32'(alu_ready), 32'd1);
    end
    push_alu(4'd1, 16'h5A5A);
    @(posedge clk);
    #1;
    chk_all("newxfer", 16'h0002, 16'h5A5A, 16'h0, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
